// File: rtl/mult_pipe.sv
// RV32M multiply pipeline (MUL/MULH/MULHSU/MULHU) with LATENCY register stages.
// Stage 1 holds two 33x17 partial products, stage 2 the selected 32-bit result.
module mult_pipe #(
  parameter int LATENCY = 4
) (
  input  logic        clk_i,
  input  logic        rsn_i,
  input  logic        stall_i,
  input  logic        flush_i,
  input  logic        mult1_int_write_enable_i,
  input  logic [31:0] mult1_rs1_data_i,
  input  logic [31:0] mult1_rs2_data_i,
  input  logic [4:0]  mult1_write_addr_i,
  input  logic [31:0] mult1_instruction_i,
  input  logic [31:0] mult1_pc_i,
  input  logic [4:0]  hz_rs1_addr_i,
  input  logic [4:0]  hz_rs2_addr_i,
  output logic        hazard_o,
  output logic [31:0] wb_int_write_data_o,
  output logic [4:0]  wb_write_addr_o,
  output logic        wb_int_write_enable_o,
  output logic [31:0] wb_instruction_o,
  output logic [31:0] wb_pc_o
);
  localparam int L = LATENCY;

  typedef struct packed {
    logic [4:0]  rd;
    logic [31:0] instr;
    logic [31:0] pc;
  } meta_t;

  meta_t [L:1]        meta_q, meta_d;
  logic  [L:1]        vld_pipe_q, vld_pipe_d;
  logic signed [49:0] pp_lo_q, pp_lo_d, pp_hi_q, pp_hi_d;
  logic  [L:2][31:0]  res_q, res_d;

  logic [2:0]  in_f3;
  logic        accept;
  logic        a_sgn, b_sgn;
  logic [32:0] a33, b33;
  logic [65:0] prod;
  logic [31:0] res_s2;
  logic        unused_prod_hi;

  always_comb begin
    in_f3  = mult1_instruction_i[14:12];
    accept = mult1_int_write_enable_i
          && (mult1_instruction_i[31:25] == 7'b0000001)
          && (mult1_instruction_i[6:0]   == 7'b0110011)
          && !in_f3[2]
          && (mult1_write_addr_i != 5'd0);
    a_sgn  = (in_f3 == 3'b001) || (in_f3 == 3'b010);
    b_sgn  = (in_f3 == 3'b001);
    a33    = {a_sgn & mult1_rs1_data_i[31], mult1_rs1_data_i};
    b33    = {b_sgn & mult1_rs2_data_i[31], mult1_rs2_data_i};
    // low limb of B is unsigned, high limb carries the extension sign
    pp_lo_d = $signed(a33) * $signed({1'b0, b33[15:0]});
    pp_hi_d = $signed(a33) * $signed(b33[32:16]);
  end

  always_comb begin
    prod   = {{16{pp_lo_q[49]}}, pp_lo_q} + {pp_hi_q, 16'b0};
    res_s2 = (meta_q[1].instr[14:12] == 3'b000) ? prod[31:0] : prod[63:32];
  end

  assign unused_prod_hi = ^prod[65:64];

  always_comb begin
    meta_d     = meta_q;
    vld_pipe_d = vld_pipe_q;
    res_d      = res_q;
    if (flush_i || !stall_i) begin
      meta_d[1]     = '{rd: mult1_write_addr_i, instr: mult1_instruction_i, pc: mult1_pc_i};
      vld_pipe_d[1] = accept & ~flush_i;
      for (int s = 2; s <= L; s++) begin
        meta_d[s]     = meta_q[s-1];
        vld_pipe_d[s] = vld_pipe_q[s-1] & ~flush_i;
      end
      res_d[2] = res_s2;
      for (int s = 3; s <= L; s++) res_d[s] = res_q[s-1];
    end
  end

  // partial products only matter when the stage-1 slot advances
  always_ff @(posedge clk_i) begin
    if (rsn_i) begin
      meta_q     <= '0;
      vld_pipe_q <= '0;
      res_q      <= '0;
      pp_lo_q    <= '0;
      pp_hi_q    <= '0;
    end else begin
      meta_q     <= meta_d;
      vld_pipe_q <= vld_pipe_d;
      res_q      <= res_d;
      if (flush_i || !stall_i) begin
        pp_lo_q <= pp_lo_d;
        pp_hi_q <= pp_hi_d;
      end
    end
  end

  always_comb begin
    hazard_o = 1'b0;
    for (int s = 1; s <= L; s++) begin
      if (vld_pipe_q[s] && (meta_q[s].rd != 5'd0) &&
          ((meta_q[s].rd == hz_rs1_addr_i) || (meta_q[s].rd == hz_rs2_addr_i)))
        hazard_o = 1'b1;
    end
  end

  assign wb_int_write_enable_o = vld_pipe_q[L];
  assign wb_int_write_data_o   = vld_pipe_q[L] ? res_q[L] : 32'd0;
  assign wb_write_addr_o       = meta_q[L].rd;
  assign wb_instruction_o      = meta_q[L].instr;
  assign wb_pc_o               = meta_q[L].pc;

endmodule

// File: tb/tb_mult_pipe.sv
// Directed bench for mult_pipe: latency, high variants, filtering, stall, flush/reset, hazard.
module tb_mult_pipe;
  localparam int LAT = 4;

  logic        clk = 1'b0;
  logic        rsn, stall, flush, we;
  logic [31:0] a, b, instr, pc;
  logic [4:0]  rd, hz1, hz2;
  logic        hazard, wb_en;
  logic [31:0] wb_data, wb_instr, wb_pc;
  logic [4:0]  wb_addr;

  int n_cmp = 0;
  int n_err = 0;

  mult_pipe #(.LATENCY(LAT)) dut (
    .clk_i(clk), .rsn_i(rsn), .stall_i(stall), .flush_i(flush),
    .mult1_int_write_enable_i(we), .mult1_rs1_data_i(a), .mult1_rs2_data_i(b),
    .mult1_write_addr_i(rd), .mult1_instruction_i(instr), .mult1_pc_i(pc),
    .hz_rs1_addr_i(hz1), .hz_rs2_addr_i(hz2), .hazard_o(hazard),
    .wb_int_write_data_o(wb_data), .wb_write_addr_o(wb_addr),
    .wb_int_write_enable_o(wb_en), .wb_instruction_o(wb_instr), .wb_pc_o(wb_pc)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] mk(input logic [2:0] f3, input logic [6:0] op);
    return {7'b0000001, 10'd0, f3, 5'd0, op};
  endfunction

  task automatic drive(input logic [2:0] f3, input logic [31:0] aa, input logic [31:0] bb,
                       input logic [4:0] r, input logic [31:0] p);
    we = 1'b1; a = aa; b = bb; rd = r; pc = p; instr = mk(f3, 7'b0110011);
  endtask

  task automatic idle;
    we = 1'b0; a = '0; b = '0; rd = '0; pc = '0; instr = '0;
  endtask

  logic [2:0]  hv_f3 [4] = '{3'b001, 3'b011, 3'b010, 3'b001};
  logic [31:0] hv_a  [4] = '{32'h80000000, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF};
  logic [31:0] hv_b  [4] = '{32'h80000000, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF};
  logic [31:0] hv_r  [4] = '{32'h40000000, 32'hFFFFFFFE, 32'hFFFFFFFF, 32'h00000000};

  initial begin
    int cnt;
    rsn = 1'b1; stall = 1'b0; flush = 1'b0; hz1 = '0; hz2 = '0;
    idle();
    tick(); tick();
    rsn = 1'b0;
    chk("rst_en",    32'(wb_en),    32'd0);
    chk("rst_data",  wb_data,       32'd0);
    chk("rst_addr",  32'(wb_addr),  32'd0);
    chk("rst_pc",    wb_pc,         32'd0);
    chk("rst_instr", wb_instr,      32'd0);
    chk("rst_hz",    32'(hazard),   32'd0);

    // basic MUL: 7 * -3
    drive(3'b000, 32'd7, 32'hFFFFFFFD, 5'd5, 32'h100);
    tick(); idle();
    tick(); tick();
    chk("mul_early_en", 32'(wb_en), 32'd0);
    tick();
    chk("mul_en",   32'(wb_en),   32'd1);
    chk("mul_data", wb_data,      32'hFFFFFFEB);
    chk("mul_addr", 32'(wb_addr), 32'd5);
    chk("mul_pc",   wb_pc,        32'h100);
    chk("mul_inst", wb_instr,     mk(3'b000, 7'b0110011));
    tick();
    chk("mul_after_en",   32'(wb_en), 32'd0);
    chk("mul_after_data", wb_data,    32'd0);

    // high variants back-to-back
    for (int i = 0; i < 4; i++) begin
      drive(hv_f3[i], hv_a[i], hv_b[i], 5'(i + 1), 32'h200 + 32'(i * 4));
      tick();
    end
    idle();
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("hv%0d_en", i),   32'(wb_en),   32'd1);
      chk($sformatf("hv%0d_data", i), wb_data,      hv_r[i]);
      chk($sformatf("hv%0d_addr", i), 32'(wb_addr), 32'(i + 1));
      tick();
    end
    chk("hv_done_en", 32'(wb_en), 32'd0);

    // filtering: DIV, non-M opcode, rd=0
    for (int k = 0; k < 3; k++) begin
      if (k == 0) begin drive(3'b100, 32'd20, 32'd4, 5'd6, 32'h300); hz1 = 5'd6; end
      if (k == 1) begin drive(3'b000, 32'd2, 32'd3, 5'd7, 32'h304);
                        instr = mk(3'b000, 7'b0010011); hz1 = 5'd7; end
      if (k == 2) begin drive(3'b000, 32'd2, 32'd3, 5'd0, 32'h308); hz1 = 5'd0; end
      tick(); idle();
      for (int c = 0; c < LAT + 1; c++) begin
        chk($sformatf("filt%0d_c%0d", k, c), {30'd0, wb_en, hazard}, 32'd0);
        tick();
      end
    end

    // stall while in flight; a valid input offered during stall must be ignored
    hz1 = 5'd9; hz2 = 5'd0;
    drive(3'b000, 32'd1000, 32'd3, 5'd9, 32'h400);
    tick(); idle();
    tick();
    stall = 1'b1;
    drive(3'b000, 32'd5, 32'd5, 5'd10, 32'h404);
    for (int c = 0; c < 3; c++) begin
      tick();
      chk($sformatf("stl_hz%0d", c), 32'(hazard), 32'd1);
      chk($sformatf("stl_en%0d", c), 32'(wb_en),  32'd0);
    end
    stall = 1'b0; idle();
    tick();
    chk("stl_pre_en", 32'(wb_en),  32'd0);
    chk("stl_pre_hz", 32'(hazard), 32'd1);
    tick();
    chk("stl_en",   32'(wb_en),   32'd1);
    chk("stl_data", wb_data,      32'd3000);
    chk("stl_addr", 32'(wb_addr), 32'd9);
    chk("stl_hz",   32'(hazard),  32'd1);
    stall = 1'b1;
    tick();
    chk("stl_hold_en",   32'(wb_en),  32'd1);
    chk("stl_hold_data", wb_data,     32'd3000);
    chk("stl_hold_hz",   32'(hazard), 32'd1);
    stall = 1'b0;
    tick();
    chk("stl_gone_en", 32'(wb_en),  32'd0);
    chk("stl_gone_hz", 32'(hazard), 32'd0);
    for (int c = 0; c < LAT; c++) begin
      tick();
      chk($sformatf("stl_nodup%0d", c), 32'(wb_en), 32'd0);
    end

    // flush with 3 in flight, valid input present during flush
    hz1 = 5'd3; hz2 = 5'd4;
    for (int i = 1; i <= 3; i++) begin
      drive(3'b000, 32'(i), 32'd2, 5'(i), 32'h500);
      tick();
    end
    chk("fl_pre_hz", 32'(hazard), 32'd1);
    flush = 1'b1;
    drive(3'b000, 32'd9, 32'd9, 5'd4, 32'h50C);
    tick();
    flush = 1'b0; idle();
    chk("fl_hz", 32'(hazard), 32'd0);
    for (int c = 0; c < LAT + 1; c++) begin
      chk($sformatf("fl_c%0d", c), {30'd0, wb_en, hazard}, 32'd0);
      tick();
    end

    // reset together with stall, final stage occupied
    hz1 = 5'd1; hz2 = 5'd2;
    for (int i = 1; i <= 4; i++) begin
      drive(3'b011, 32'(i), 32'd2, 5'(i), 32'h600 + 32'(i));
      tick();
    end
    chk("rs_pre_en", 32'(wb_en), 32'd1);
    rsn = 1'b1; stall = 1'b1;
    tick();
    rsn = 1'b0; stall = 1'b0; idle();
    chk("rs_en",    32'(wb_en),   32'd0);
    chk("rs_data",  wb_data,      32'd0);
    chk("rs_addr",  32'(wb_addr), 32'd0);
    chk("rs_instr", wb_instr,     32'd0);
    chk("rs_pc",    wb_pc,        32'd0);
    chk("rs_hz",    32'(hazard),  32'd0);
    for (int c = 0; c < LAT + 1; c++) begin
      tick();
      chk($sformatf("rs_c%0d", c), {30'd0, wb_en, hazard}, 32'd0);
    end

    // hazard window length: rs1 match, rs2 miss, rs2 match
    for (int k = 0; k < 3; k++) begin
      hz1 = (k == 0) ? 5'd12 : 5'd0;
      hz2 = (k == 1) ? 5'd13 : ((k == 2) ? 5'd12 : 5'd0);
      cnt = 0;
      drive(3'b000, 32'd6, 32'd7, 5'd12, 32'h700);
      for (int c = 0; c < LAT + 4; c++) begin
        tick();
        if (c == 0) idle();
        cnt += int'(hazard);
      end
      chk($sformatf("hz_cnt%0d", k), 32'(cnt), (k == 1) ? 32'd0 : 32'(LAT));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
